// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the PC-stage state encoding.
package riscv_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_JALR = 3'b000;

    typedef enum logic [1:0] {
        PCU_BOOT      = 2'd0,
        PCU_RUN       = 2'd1,
        PCU_WAIT_TRAP = 2'd2
    } pcu_state_e;

endpackage

// File: rtl/branch_eval.sv
// Branch condition resolver: maps funct3 and the comparator flags to a taken decision.
module branch_eval
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       cmp_zero,
    input  logic       cmp_lt,
    input  logic       cmp_ltu,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (funct3)
            F3_BEQ:  cond_true = cmp_zero;
            F3_BNE:  cond_true = !cmp_zero;
            F3_BLT:  cond_true = cmp_lt;
            F3_BGE:  cond_true = !cmp_lt;
            F3_BLTU: cond_true = cmp_ltu;
            F3_BGEU: cond_true = !cmp_ltu;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/next_pc_unit.sv
// Program-counter stage: holds the architectural PC and selects sequential, branch,
// jump or trap next-fetch addresses, with registered redirect/misalign pulses.
//
// state         | meaning
// PCU_BOOT      | first cycle after reset, pc not yet fetchable
// PCU_RUN       | evaluating instructions at pc
// PCU_WAIT_TRAP | misaligned target seen, pc frozen until trap_req
module next_pc_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     ALIGN_BITS   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic            instr_valid,
    input  logic            stall,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            cmp_zero,
    input  logic            cmp_lt,
    input  logic            cmp_ltu,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_vec,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic [XLEN-1:0] link,
    output logic            taken,
    output logic            flush,
    output logic            misalign
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    pcu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_d;
    logic            pc_valid_d, taken_d, flush_d, misalign_d;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_b, imm_j, imm_i;
    logic [XLEN-1:0] target;
    logic            redirect, br_true;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign imm_b  = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j  = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign link   = pc + XLEN'(4);

    branch_eval u_branch_eval (
        .funct3    (funct3),
        .cmp_zero  (cmp_zero),
        .cmp_lt    (cmp_lt),
        .cmp_ltu   (cmp_ltu),
        .cond_true (br_true)
    );

    always_comb begin
        redirect = 1'b0;
        target   = pc + imm_b;
        case (opcode)
            OP_BRANCH: redirect = br_true;
            OP_JAL: begin
                redirect = 1'b1;
                target   = pc + imm_j;
            end
            OP_JALR: begin
                redirect = (funct3 == F3_JALR);
                target   = (rs1_val + imm_i) & ~XLEN'(1);
            end
            default: redirect = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc;
        pc_valid_d = pc_valid;
        taken_d    = 1'b0;
        flush_d    = 1'b0;
        misalign_d = 1'b0;
        if (state_q != PCU_BOOT && trap_req) begin
            state_d    = PCU_RUN;
            pc_d       = trap_vec;
            pc_valid_d = 1'b1;
            flush_d    = 1'b1;
        end else begin
            case (state_q)
                PCU_BOOT: begin
                    state_d    = PCU_RUN;
                    pc_valid_d = 1'b1;
                end
                PCU_RUN: begin
                    if (!stall && instr_valid) begin
                        if (!redirect) begin
                            pc_d = link;
                        end else if ((target & ALIGN_MASK) != '0) begin
                            // keep pc at the offending instruction for the trap handler
                            state_d    = PCU_WAIT_TRAP;
                            pc_valid_d = 1'b0;
                            misalign_d = 1'b1;
                        end else begin
                            pc_d    = target;
                            taken_d = 1'b1;
                            flush_d = 1'b1;
                        end
                    end
                end
                PCU_WAIT_TRAP: state_d = PCU_WAIT_TRAP;
                default:       state_d = PCU_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= PCU_BOOT;
            pc       <= RESET_VECTOR;
            pc_valid <= 1'b0;
            taken    <= 1'b0;
            flush    <= 1'b0;
            misalign <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc       <= pc_d;
            pc_valid <= pc_valid_d;
            taken    <= taken_d;
            flush    <= flush_d;
            misalign <= misalign_d;
        end
    end

endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboarded bench for next_pc_unit: two instances (ALIGN_BITS 2 and 1) share stimulus.
module tb_next_pc_unit;

    logic        clk = 1'b0;
    logic        rst, instr_valid, stall, cmp_zero, cmp_lt, cmp_ltu, trap_req;
    logic [31:0] instr, rs1_val, trap_vec;
    logic [31:0] pc_a, link_a, pc_b, link_b;
    logic        pc_valid_a, taken_a, flush_a, misalign_a;
    logic        pc_valid_b, taken_b, flush_b, misalign_b;

    next_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .ALIGN_BITS(2)) dut_a (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .stall(stall),
        .rs1_val(rs1_val), .cmp_zero(cmp_zero), .cmp_lt(cmp_lt), .cmp_ltu(cmp_ltu),
        .trap_req(trap_req), .trap_vec(trap_vec), .pc(pc_a), .pc_valid(pc_valid_a),
        .link(link_a), .taken(taken_a), .flush(flush_a), .misalign(misalign_a));

    next_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .ALIGN_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .stall(stall),
        .rs1_val(rs1_val), .cmp_zero(cmp_zero), .cmp_lt(cmp_lt), .cmp_ltu(cmp_ltu),
        .trap_req(trap_req), .trap_vec(trap_vec), .pc(pc_b), .pc_valid(pc_valid_b),
        .link(link_b), .taken(taken_b), .flush(flush_b), .misalign(misalign_b));

    always #5 clk = ~clk;

    typedef enum int {M_BOOT, M_RUN, M_WAIT} mode_t;
    typedef struct {
        mode_t       mode;
        logic [31:0] pc;
        bit          pc_valid, taken, flush, misalign;
    } mdl_t;
    typedef struct {
        bit          rst, iv, stall, trap;
        logic [31:0] instr, a, b, tvec;
    } stim_t;
    typedef struct {
        mdl_t ea, eb;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    mdl_t  ma, mb;
    int    n_checks = 0;
    int    n_fail   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic mdl_t reset_model();
        mdl_t m;
        m.mode = M_BOOT; m.pc = 32'h0; m.pc_valid = 0;
        m.taken = 0; m.flush = 0; m.misalign = 0;
        return m;
    endfunction

    // Reference: next architectural view after one edge, from the instruction semantics.
    function automatic mdl_t step(mdl_t m, stim_t s, int align);
        mdl_t              n;
        logic [6:0]        opc;
        logic [2:0]        f3;
        logic signed [12:0] bo;
        logic signed [20:0] jo;
        logic signed [11:0] io;
        int                bi, ji, ii;
        bit                go;
        logic [31:0]       tgt;
        n = m; n.taken = 0; n.flush = 0; n.misalign = 0;
        if (s.rst) return reset_model();
        if (m.mode == M_BOOT) begin
            n.mode = M_RUN; n.pc_valid = 1;
            return n;
        end
        if (s.trap) begin
            n.mode = M_RUN; n.pc = s.tvec; n.pc_valid = 1; n.flush = 1;
            return n;
        end
        if (m.mode == M_WAIT || s.stall || !s.iv) return n;
        opc = s.instr[6:0];
        f3  = s.instr[14:12];
        bo  = {s.instr[31], s.instr[7], s.instr[30:25], s.instr[11:8], 1'b0};
        jo  = {s.instr[31], s.instr[19:12], s.instr[20], s.instr[30:21], 1'b0};
        io  = s.instr[31:20];
        bi = bo; ji = jo; ii = io;
        go = 0; tgt = 32'h0;
        if (opc == 7'b1100011) begin
            case (f3)
                3'd0: go = (s.a == s.b);
                3'd1: go = (s.a != s.b);
                3'd4: go = ($signed(s.a) <  $signed(s.b));
                3'd5: go = ($signed(s.a) >= $signed(s.b));
                3'd6: go = (s.a <  s.b);
                3'd7: go = (s.a >= s.b);
                default: go = 0;
            endcase
            tgt = m.pc + bi;
        end else if (opc == 7'b1101111) begin
            go = 1; tgt = m.pc + ji;
        end else if (opc == 7'b1100111 && f3 == 3'd0) begin
            go = 1; tgt = (s.a + ii) & 32'hFFFF_FFFE;
        end
        if (!go) begin
            n.pc = m.pc + 32'd4;
        end else if ((tgt % (32'd1 << align)) != 0) begin
            n.misalign = 1; n.pc_valid = 0; n.mode = M_WAIT;
        end else begin
            n.pc = tgt; n.taken = 1; n.flush = 1;
        end
        return n;
    endfunction

    function automatic logic [31:0] enc_b(logic [2:0] f3, int off);
        logic [12:0] o;
        o = off[12:0];
        return {o[12], o[10:5], 5'd2, 5'd1, f3, o[4:1], o[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jal(int off);
        logic [20:0] o;
        o = off[20:0];
        return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(logic [2:0] f3, int imm);
        logic [11:0] i;
        i = imm[11:0];
        return {i, 5'd1, f3, 5'd1, 7'b1100111};
    endfunction

    task automatic apply(string nm, stim_t s);
        exp_t e;
        @(negedge clk);
        rst         = s.rst;
        instr_valid = s.iv;
        stall       = s.stall;
        instr       = s.instr;
        rs1_val     = s.a;
        cmp_zero    = (s.a == s.b);
        cmp_lt      = ($signed(s.a) < $signed(s.b));
        cmp_ltu     = (s.a < s.b);
        trap_req    = s.trap;
        trap_vec    = s.tvec;
        ma = step(ma, s, 2);
        mb = step(mb, s, 1);
        e.ea = ma; e.eb = mb;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    function automatic stim_t mk(bit r, bit iv, bit st, logic [31:0] ins,
                                 logic [31:0] a, logic [31:0] b, bit tr, logic [31:0] tv);
        stim_t s;
        s.rst = r; s.iv = iv; s.stall = st; s.instr = ins;
        s.a = a; s.b = b; s.trap = tr; s.tvec = tv;
        return s;
    endfunction

    task automatic run_instr(string nm, logic [31:0] ins, logic [31:0] a, logic [31:0] b);
        apply(nm, mk(0, 1, 0, ins, a, b, 0, 32'h0));
    endtask

    task automatic trap_to(string nm, logic [31:0] addr);
        apply(nm, mk(0, 0, 0, NOP, 0, 0, 1, addr));
    endtask

    task automatic chk(string nm, string field, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s %s: got %h expected %h", nm, field, act, expv);
        end
    endtask

    task automatic cmp_dut(string nm, mdl_t e, logic [31:0] p, logic [31:0] l,
                           logic pv, logic tk, logic fl, logic mi);
        chk(nm, "pc", p, e.pc);
        chk(nm, "link", l, e.pc + 32'd4);
        chk(nm, "pc_valid", {31'd0, pv}, {31'd0, e.pc_valid});
        chk(nm, "taken", {31'd0, tk}, {31'd0, e.taken});
        chk(nm, "flush", {31'd0, fl}, {31'd0, e.flush});
        chk(nm, "misalign", {31'd0, mi}, {31'd0, e.misalign});
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                cmp_dut({nm, "/a2"}, e.ea, pc_a, link_a, pc_valid_a, taken_a, flush_a, misalign_a);
                cmp_dut({nm, "/a1"}, e.eb, pc_b, link_b, pc_valid_b, taken_b, flush_b, misalign_b);
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        case ($urandom_range(0, 5))
            0: r = NOP;
            1: r = enc_b(3'($urandom_range(0, 7)), 2 * ($urandom_range(0, 64) - 32));
            2: r = enc_jal(2 * ($urandom_range(0, 256) - 128));
            3: r = enc_jalr(($urandom_range(0, 3) == 0) ? 3'd1 : 3'd0,
                            $urandom_range(0, 4095) - 2048);
            4: r = enc_b(3'($urandom_range(0, 7)), 4 * ($urandom_range(0, 32) - 16));
            default: r = $urandom;
        endcase
        return r;
    endfunction

    initial begin : stimulus
        stim_t       s;
        logic [31:0] a, b;
        rst = 1; instr_valid = 0; stall = 0; instr = NOP; rs1_val = 0;
        cmp_zero = 0; cmp_lt = 0; cmp_ltu = 0; trap_req = 0; trap_vec = 0;
        ma = reset_model();
        mb = reset_model();

        apply("reset0", mk(1, 0, 0, NOP, 0, 0, 0, 0));
        apply("reset1", mk(1, 1, 0, NOP, 0, 0, 1, 32'h40));
        apply("boot_trap_ignored", mk(0, 1, 0, NOP, 0, 0, 1, 32'h40));
        run_instr("seq4", NOP, 0, 0);
        run_instr("seq8", NOP, 0, 0);
        run_instr("seqC", NOP, 0, 0);

        trap_to("to100", 32'h100);
        run_instr("bne_taken", enc_b(3'b001, -8), 32'd1, 32'd2);
        trap_to("to100b", 32'h100);
        run_instr("bne_not_taken", enc_b(3'b001, -8), 32'd5, 32'd5);
        run_instr("blt_taken", enc_b(3'b100, 16), 32'hFFFF_FFFF, 32'h0);
        run_instr("bltu_not_taken", enc_b(3'b110, 16), 32'hFFFF_FFFF, 32'h0);
        run_instr("f3_010", enc_b(3'b010, 16), 32'h3, 32'h3);
        run_instr("beq_taken", enc_b(3'b000, -12), 32'h7, 32'h7);
        run_instr("bge_taken", enc_b(3'b101, 20), 32'h0, 32'hFFFF_FFFF);
        run_instr("bgeu_taken", enc_b(3'b111, 24), 32'hFFFF_FFFF, 32'h0);

        run_instr("jalr_1003", enc_jalr(3'b000, 0), 32'h0000_1003, 0);
        apply("wait_stall", mk(0, 1, 1, enc_jal(64), 0, 0, 0, 0));
        run_instr("wait_ignore", enc_jal(64), 0, 0);
        trap_to("trap200", 32'h200);

        apply("stall_jal0", mk(0, 1, 1, enc_jal(64), 0, 0, 0, 0));
        apply("stall_jal1", mk(0, 1, 1, enc_jal(64), 0, 0, 0, 0));
        apply("stall_jal2", mk(0, 1, 1, enc_jal(64), 0, 0, 0, 0));
        run_instr("jal_go", enc_jal(64), 0, 0);
        apply("idle_hold", mk(0, 0, 0, enc_jal(64), 0, 0, 0, 0));

        trap_to("to_top", 32'hFFFF_FFFC);
        run_instr("wrap", NOP, 0, 0);

        trap_to("to300", 32'h300);
        apply("rst_and_trap", mk(1, 1, 0, enc_jal(8), 0, 0, 1, 32'h500));
        run_instr("boot_again", NOP, 0, 0);
        apply("trap_beats_branch", mk(0, 1, 0, enc_b(3'b000, 16), 9, 9, 1, 32'h600));
        apply("trap_beats_stall", mk(0, 1, 1, enc_b(3'b000, 16), 9, 9, 1, 32'h700));
        run_instr("jal_misalign2", enc_jal(6), 0, 0);
        apply("rst_in_wait", mk(1, 0, 0, NOP, 0, 0, 0, 0));

        for (int i = 0; i < 500; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            s = mk(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 4) == 0), rand_instr(), a, b,
                   ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFE)
                                               : ($urandom & 32'hFFFF_FFFC));
            apply("random", s);
        end

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Parametrised program-counter stage for the RV32I core. Holds the architectural PC and computes the next fetch address each cycle: sequential +4, conditional branches (all six RV32I conditions), JAL, JALR and trap redirection. It supports pipeline stalls, flags misaligned control-flow targets and emits a registered flush pulse on every redirect. It replaces the combinational PC-increment selector and drives instruction fetch and the link-register write path.

## Interface
- XLEN, 32, address/data width
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits)
- ALIGN_BITS, 2, required target alignment in low bits: 2 = IALIGN 32, 1 = compressed-capable

- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  32  instruction currently at `pc`
- instr_valid  in  1  `instr` is valid this cycle
- stall  in  1  hold PC, do not evaluate `instr`
- rs1_val  in  XLEN  rs1 operand (JALR base)
- cmp_zero  in  1  rs1 == rs2
- cmp_lt  in  1  rs1 < rs2, signed
- cmp_ltu  in  1  rs1 < rs2, unsigned
- trap_req  in  1  redirect to `trap_vec`
- trap_vec  in  XLEN  trap target
- pc  out  XLEN  current PC (registered)
- pc_valid  out  1  `pc` is a fetchable address
- link  out  XLEN  pc + 4 (combinational), for JAL/JALR rd
- taken  out  1  last evaluated instruction redirected (registered)
- flush  out  1  one-cycle pulse: younger fetched work is invalid
- misalign  out  1  one-cycle pulse: computed target violated alignment

## Operation
- FSM states: BOOT, RUN, WAIT_TRAP.
- Reset: state BOOT; pc=RESET_VECTOR, pc_valid=0, taken=0, flush=0, misalign=0; link=RESET_VECTOR+4.
- BOOT → RUN after one cycle. pc is unchanged. pc_valid rises on entry to RUN.
- In RUN, an instruction is evaluated when instr_valid=1 and stall=0. The decoded target is:
  - BRANCH (opcode 1100011): B-imm = sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
    - funct3 000 BEQ: cmp_zero
    - 001 BNE: !cmp_zero
    - 100 BLT: cmp_lt
    - 101 BGE: !cmp_lt
    - 110 BLTU: cmp_ltu
    - 111 BGEU: !cmp_ltu
    - 010/011: not taken
    - Taken target = pc + B-imm.
  - JAL (1101111): target = pc + sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}; always taken.
  - JALR (1100111, funct3 000): target = (rs1_val + sign-extend instr[31:20]) & ~1; always taken.
  - Otherwise, or branch not taken: next = pc + 4, taken=0.
- Taken and target aligned: pc ← target, taken=1, flush=1 next cycle.
- Taken but target[ALIGN_BITS-1:0] ≠ 0: pc holds, misalign=1 for one cycle, pc_valid=0, state → WAIT_TRAP.
- WAIT_TRAP: ignore instr and stall; hold until trap_req.
- trap_req in any state except BOOT: pc ← trap_vec, flush=1, taken=0, misalign=0, state → RUN, pc_valid=1. trap_req overrides stall and any branch.
- instr_valid=0 and stall=0 in RUN: pc holds; taken, flush and misalign are 0.
- Arithmetic is modulo 2^XLEN. pc=FFFF_FFFC with +4 wraps to 0000_0000 with no error.

## Timing
- Next-PC latency is 1 cycle: the result for `instr` at edge N appears on `pc` after edge N+1.
- flush, taken and misalign are registered and valid in the same cycle as the new pc. Each is 1 cycle wide unless retriggered.
- stall=1 in RUN: pc, pc_valid and state hold; taken, flush and misalign are 0 that cycle.
- rst is sampled on the clock edge and beats every other input, including a simultaneous trap_req.
- Reset asserted mid-redirect or in WAIT_TRAP gives the full reset values on the next edge.
- Priority: rst > trap_req > stall > instruction evaluation.

## Structure
- Shared `riscv_pkg`:
  - opcode constants: OP_BRANCH, OP_JAL, OP_JALR
  - branch funct3 constants: F3_BEQ … F3_BGEU
  - FSM state encoding: PCU_BOOT, PCU_RUN, PCU_WAIT_TRAP
- Sub-module `branch_eval`: combinational; funct3 and the comparison flags in, `cond_true` out. It is reused by the future branch predictor checker.
- Immediate extraction stays inline; there are no other sub-modules.

## Test plan
- Reset, then release: pc=0000_0000 with pc_valid=0 for 1 cycle, then pc_valid=1. With NOP-class instructions pc steps 4, 8, C.
- At pc=0000_0100, BNE with offset −8 and cmp_zero=0: the next pc is 0000_00F8 with taken=1 and flush=1. The same instruction with cmp_zero=1 gives pc=0000_0104 and flush=0.
- Directed cases, one per branch funct3:
  - BLT: cmp_lt=1, cmp_ltu=0 → taken
  - BLTU: cmp_lt=1, cmp_ltu=0 → not taken
  - funct3=010 → pc+4
- JALR with rs1_val=0000_1003 and imm=0 gives target 0000_1002:
  - ALIGN_BITS=2: misalign pulses, pc holds and pc_valid=0 until trap_req with trap_vec=0000_0200, then pc=0000_0200 and flush=1.
  - ALIGN_BITS=1: pc=0000_1002.
- stall=1 for 3 cycles during a taken JAL: pc is frozen and no flush occurs. The redirect happens on the first unstalled cycle.
- Boundary and priority cases:
  - pc=FFFF_FFFC with a sequential instruction: pc wraps to 0000_0000.
  - trap_req and rst high on the same edge: reset values result.
  - trap_req with a taken branch: trap_vec wins.
